// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the single register-file write port.
// Optional grant/conflict statistics counters: define WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_rd,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_rd,
  input  logic [DATA_W-1:0] p1_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_in,
  output logic [NREGS-1:0]  pending_mask,
  output logic              err_oob,
  input  logic              err_clr
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt
`endif
);

  function automatic logic in_range(input logic [ADDR_W-1:0] rd);
    return int'(rd) < NREGS;
  endfunction

  logic              h0_vld_p0, h1_vld_p0;
  logic [ADDR_W-1:0] h0_rd_p0, h1_rd_p0;
  logic [DATA_W-1:0] h0_data_p0, h1_data_p0;
  logic              h1_older_p0;
  logic              rr_last;

  logic              both, g0, g1, g_vld, g_wr, g_oob, acc0, acc1;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;

  always_comb begin
    both = h0_vld_p0 && h1_vld_p0;
    g0   = 1'b0;
    g1   = 1'b0;
    if (both) begin
      // Same destination: age decides; otherwise alternate against the last contention winner.
      g1 = (h0_rd_p0 == h1_rd_p0) ? h1_older_p0 : ~rr_last;
      g0 = ~g1;
    end else begin
      g0 = h0_vld_p0;
      g1 = h1_vld_p0;
    end
    g_vld  = g0 || g1;
    g_rd   = g1 ? h1_rd_p0 : h0_rd_p0;
    g_data = g1 ? h1_data_p0 : h0_data_p0;
    g_wr   = g_vld && in_range(g_rd) && (g_rd != '0);
    g_oob  = g_vld && !in_range(g_rd);
  end

  assign p0_ready = !h0_vld_p0 || g0;
  assign p1_ready = !h1_vld_p0 || g1;
  assign acc0     = p0_valid && p0_ready;
  assign acc1     = p1_valid && p1_ready;

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < NREGS; r++) begin
      pending_mask[r] = (h0_vld_p0 && int'(h0_rd_p0) == r) ||
                        (h1_vld_p0 && int'(h1_rd_p0) == r);
    end
  end

  // Stage p0: holding registers and arbitration state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_vld_p0   <= 1'b0;
      h1_vld_p0   <= 1'b0;
      h1_older_p0 <= 1'b0;
      rr_last     <= 1'b1;
    end else begin
      h0_vld_p0 <= acc0 || (h0_vld_p0 && !g0);
      h1_vld_p0 <= acc1 || (h1_vld_p0 && !g1);
      if (acc1)
        h1_older_p0 <= 1'b0;
      else if (acc0)
        h1_older_p0 <= 1'b1;
      if (both)
        rr_last <= g1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) begin
      h0_rd_p0   <= p0_rd;
      h0_data_p0 <= p0_data;
    end
    if (acc1) begin
      h1_rd_p0   <= p1_rd;
      h1_data_p0 <= p1_data;
    end
  end

  // Stage p1: registered register-file write port and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write <= 1'b0;
      rf_rd    <= '0;
      rf_in    <= '0;
      err_oob  <= 1'b0;
    end else begin
      rf_write <= g_wr;
      if (g_wr) begin
        rf_rd <= g_rd;
        rf_in <= g_data;
      end
      if (g_oob)
        err_oob <= 1'b1;
      else if (err_clr)
        err_oob <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (g0)
        grant_cnt0 <= sat_inc(grant_cnt0);
      if (g1)
        grant_cnt1 <= sat_inc(grant_cnt1);
      if (both)
        conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset sequence, and
// randomized traffic against an entry/age-based reference model.
module tb_regfile_wb_arbiter;

  localparam int NREGS = 16;

  logic        clk, rst_n;
  logic        p0_valid, p0_ready, p1_valid, p1_ready;
  logic [4:0]  p0_rd, p1_rd, rf_rd;
  logic [31:0] p0_data, p1_data, rf_in;
  logic        rf_write, err_oob, err_clr;
  logic [15:0] pending_mask;
`ifdef WB_ARB_STATS_EN
  logic [15:0] gc0, gc1, cc;
`endif

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_data(p1_data),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_in(rf_in),
    .pending_mask(pending_mask), .err_oob(err_oob), .err_clr(err_clr)
`ifdef WB_ARB_STATS_EN
    , .grant_cnt0(gc0), .grant_cnt1(gc1), .conflict_cnt(cc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct {
    logic v0; logic [4:0] rd0; logic [31:0] d0;
    logic v1; logic [4:0] rd1; logic [31:0] d1;
    logic clr;
    logic ew; logic [4:0] erd; logic [31:0] ein;
    logic [15:0] emask; logic er0, er1, eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int v0, input int rd0, input logic [31:0] d0,
                     input int v1, input int rd1, input logic [31:0] d1, input int clr,
                     input int ew, input int erd, input logic [31:0] ein,
                     input int emask, input int er0, input int er1, input int eerr);
    vec_t e;
    e.v0 = v0[0]; e.rd0 = rd0[4:0]; e.d0 = d0;
    e.v1 = v1[0]; e.rd1 = rd1[4:0]; e.d1 = d1;
    e.clr = clr[0];
    e.ew = ew[0]; e.erd = erd[4:0]; e.ein = ein;
    e.emask = emask[15:0]; e.er0 = er0[0]; e.er1 = er1[0]; e.eerr = eerr[0];
    tbl.push_back(e);
  endtask

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic clr);
    p0_valid = v0; p0_rd = rd0; p0_data = d0;
    p1_valid = v1; p1_rd = rd1; p1_data = d1;
    err_clr = clr;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Reference model: each hold is an entry with an acceptance sequence number.
  bit          mv[2];
  int          mrd[2];
  logic [31:0] md[2];
  int          mseq[2];
  int          seqc, rr;
  bit          merr;

  function automatic int model_grant();
    if (!mv[0] && !mv[1]) return -1;
    if (!mv[1]) return 0;
    if (!mv[0]) return 1;
    if (mrd[0] == mrd[1]) return (mseq[0] < mseq[1]) ? 0 : 1;
    return 1 - rr;
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    for (int p = 0; p < 2; p++)
      if (mv[p] && mrd[p] > 0 && mrd[p] < NREGS) m = m | (16'd1 << mrd[p]);
    return m;
  endfunction

  function automatic int pick_rd();
    case ($urandom_range(0, 7))
      0: return 0;
      1, 7: return 3;
      2: return 9;
      3: return 15;
      4: return 16;
      5: return 20;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    chk("reset_rf_write", 64'(rf_write), 64'd0);
    chk("reset_rf_rd", 64'(rf_rd), 64'd0);
    chk("reset_rf_in", 64'(rf_in), 64'd0);
    chk("reset_mask", 64'(pending_mask), 64'd0);
    chk("reset_err", 64'(err_oob), 64'd0);
    chk("reset_ready", 64'({p0_ready, p1_ready}), 64'd3);

    // Expectations are the outputs seen just after the edge that consumes each row.
    add(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  0, 0, 0,            'h020, 1, 1, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, 5, 32'hDEADBEEF, 'h000, 1, 1, 0);
    add(1, 0, 1,            0, 0, 0, 0,  0, 0, 0,            'h000, 1, 1, 0);
    add(0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            'h000, 1, 1, 0);
    add(1, 20, 2,           0, 0, 0, 0,  0, 0, 0,            'h000, 1, 1, 0);
    add(0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            'h000, 1, 1, 1);
    add(0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            'h000, 1, 1, 1);
    add(0, 0, 0,            0, 0, 0, 1,  0, 0, 0,            'h000, 1, 1, 0);
    add(1, 3, 32'h33,       1, 7, 32'h77, 0, 0, 0, 0,        'h088, 1, 0, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, 3, 32'h33,       'h080, 1, 1, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, 7, 32'h77,       'h000, 1, 1, 0);
    add(1, 4, 32'hA,        1, 4, 32'hB, 0, 0, 0, 0,         'h010, 1, 0, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, 4, 32'hA,        'h010, 1, 1, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, 4, 32'hB,        'h000, 1, 1, 0);
    add(0, 0, 0,            1, 9, 1, 0,  0, 0, 0,            'h200, 1, 1, 0);
    add(1, 9, 2,            0, 0, 0, 0,  1, 9, 1,            'h200, 1, 1, 0);
    add(0, 0, 0,            0, 0, 0, 0,  1, 9, 2,            'h000, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1, tbl[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rf_write", i), 64'(rf_write), 64'(tbl[i].ew));
      if (tbl[i].ew) begin
        chk($sformatf("vec%0d_rf_rd", i), 64'(rf_rd), 64'(tbl[i].erd));
        chk($sformatf("vec%0d_rf_in", i), 64'(rf_in), 64'(tbl[i].ein));
      end
      chk($sformatf("vec%0d_mask", i), 64'(pending_mask), 64'(tbl[i].emask));
      chk($sformatf("vec%0d_p0_ready", i), 64'(p0_ready), 64'(tbl[i].er0));
      chk($sformatf("vec%0d_p1_ready", i), 64'(p1_ready), 64'(tbl[i].er1));
      chk($sformatf("vec%0d_err", i), 64'(err_oob), 64'(tbl[i].eerr));
    end

    // Asynchronous reset with both holds full.
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("prerst_rf_rd", 64'(rf_rd), 64'd9);
    chk("prerst_mask", 64'(pending_mask), 64'h088);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rf_rd", 64'(rf_rd), 64'd0);
    chk("midrst_rf_in", 64'(rf_in), 64'd0);
    chk("midrst_mask", 64'(pending_mask), 64'd0);
    chk("midrst_ready", 64'({p0_ready, p1_ready}), 64'd3);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_no_write", 64'(rf_write), 64'd0);
    end
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("postrst_first_write", 64'(rf_write), 64'd1);
    chk("postrst_first_rd", 64'(rf_rd), 64'd3);
    @(posedge clk);
    #1;
    chk("postrst_second_rd", 64'(rf_rd), 64'd7);

    // Randomized traffic against the reference model.
    do_reset();
    mv[0] = 0; mv[1] = 0; seqc = 0; rr = 1; merr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g, ew, erd;
      bit vin[2], seterr, clr;
      int rdin[2];
      logic [31:0] din[2], ein;
      g = model_grant();
      chk("rnd_p0_ready", 64'(p0_ready), 64'(!mv[0] || g == 0));
      chk("rnd_p1_ready", 64'(p1_ready), 64'(!mv[1] || g == 1));
      chk("rnd_mask", 64'(pending_mask), 64'(model_mask()));
      for (int p = 0; p < 2; p++) begin
        vin[p]  = $urandom_range(0, 9) < 7;
        rdin[p] = pick_rd();
        din[p]  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) rdin[1] = rdin[0];
      clr = $urandom_range(0, 9) == 0;
      drive(vin[0], rdin[0][4:0], din[0], vin[1], rdin[1][4:0], din[1], clr);
      @(posedge clk);
      ew = 0; erd = 0; ein = '0; seterr = 0;
      if (g >= 0) begin
        if (mrd[g] != 0 && mrd[g] < NREGS) begin
          ew = 1; erd = mrd[g]; ein = md[g];
        end
        if (mrd[g] >= NREGS) seterr = 1;
        if (mv[0] && mv[1]) rr = g;
      end
      if (seterr) merr = 1;
      else if (clr) merr = 0;
      for (int p = 0; p < 2; p++) begin
        bit rdy;
        rdy = !mv[p] || g == p;
        if (g == p) mv[p] = 0;
        if (vin[p] && rdy) begin
          mv[p] = 1; mrd[p] = rdin[p]; md[p] = din[p]; mseq[p] = seqc; seqc++;
        end
      end
      #1;
      chk("rnd_rf_write", 64'(rf_write), 64'(ew));
      if (ew != 0) begin
        chk("rnd_rf_rd", 64'(rf_rd), 64'(erd));
        chk("rnd_rf_in", 64'(rf_in), 64'(ein));
      end
      chk("rnd_err", 64'(err_oob), 64'(merr));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
